// File: rtl/gmsk_burst_sequencer.sv
// GSM normal-burst sequencer. It frames upstream payload bits with tail, stealing, training
// and guard symbols, and steps one symbol per GMSK modulator next-symbol strobe.
module gmsk_burst_sequencer #(
    parameter int TAIL_LEN  = 3,
    parameter int DATA_LEN  = 57,
    parameter int TRAIN_LEN = 26,
    parameter int GUARD_LEN = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [TRAIN_LEN-1:0] train_seq,
    input  logic [1:0]           steal_flags,
    input  logic                 data_bit,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic                 symbol_strobe,
    output logic                 current_symbol,
    output logic                 tx_enable,
    output logic                 busy,
    output logic                 burst_done,
    output logic                 underrun
);
    typedef enum logic [3:0] {
        IDLE, HEAD, DATA_A, STEAL_A, TRAIN, STEAL_B, DATA_B, TAIL, GUARD
    } state_t;

    localparam logic [6:0] FETCH_TOTAL = 7'(2 * DATA_LEN);

    state_t               state;
    state_t               state_next;
    logic [5:0]           count;
    logic [5:0]           count_next;
    logic [5:0]           state_len;
    logic                 state_bit;
    logic [6:0]           fetched;
    logic                 buf_valid;
    logic                 buf_bit;
    logic [TRAIN_LEN-1:0] train_q;
    logic [1:0]           steal_q;
    logic                 accept;
    logic                 emit;
    logic                 last_symbol;
    logic                 data_slot;
    logic                 load;

    assign busy        = (state != IDLE);
    assign tx_enable   = busy;
    assign accept      = start && (state == IDLE);
    assign emit        = symbol_strobe && busy;
    assign data_slot   = (state == DATA_A) || (state == DATA_B);
    assign last_symbol = (count == state_len - 6'd1);
    assign data_ready  = busy && !buf_valid && (fetched < FETCH_TOTAL);
    assign load        = data_valid && data_ready;
    assign burst_done  = emit && (state == GUARD) && last_symbol;

    // NOTE: every variable gets a default first so no path through the block infers a latch.
    always_comb begin
        state_len  = 6'd1;
        state_bit  = 1'b0;
        state_next = state;
        count_next = count;

        case (state)
            HEAD:    state_len = 6'(TAIL_LEN);
            DATA_A,
            DATA_B: begin
                state_len = 6'(DATA_LEN);
                state_bit = buf_valid && buf_bit;  // empty buffer emits 0 (underrun)
            end
            STEAL_A: state_bit = steal_q[1];
            TRAIN: begin
                state_len = 6'(TRAIN_LEN);
                state_bit = train_q[TRAIN_LEN-1];
            end
            STEAL_B: state_bit = steal_q[0];
            TAIL:    state_len = 6'(TAIL_LEN);
            GUARD: begin
                state_len = 6'(GUARD_LEN);
                state_bit = 1'b1;
            end
            default: ;
        endcase

        if (accept) begin
            state_next = HEAD;
            count_next = '0;
        end else if (emit) begin
            if (last_symbol) begin
                count_next = '0;
                case (state)
                    HEAD:    state_next = DATA_A;
                    DATA_A:  state_next = STEAL_A;
                    STEAL_A: state_next = TRAIN;
                    TRAIN:   state_next = STEAL_B;
                    STEAL_B: state_next = DATA_B;
                    DATA_B:  state_next = TAIL;
                    TAIL:    state_next = GUARD;
                    default: state_next = IDLE;
                endcase
            end else begin
                count_next = count + 6'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // NOTE: latched burst parameters are cleared on reset too, so an aborted burst leaves nothing behind.
    always_ff @(posedge clock) begin
        if (!reset) begin
            current_symbol <= 1'b0;
            underrun       <= 1'b0;
            fetched        <= '0;
            buf_valid      <= 1'b0;
            buf_bit        <= 1'b0;
            train_q        <= '0;
            steal_q        <= '0;
        end else if (accept) begin
            train_q   <= train_seq;
            steal_q   <= steal_flags;
            underrun  <= 1'b0;
            fetched   <= '0;
            buf_valid <= 1'b0;
        end else begin
            if (emit) begin
                current_symbol <= state_bit;
                if (state == TRAIN) begin
                    train_q <= train_q << 1;
                end
            end
            if (emit && data_slot && !buf_valid) begin
                underrun <= 1'b1;
            end
            // A full buffer is never loaded, so consuming and loading cannot collide.
            if (emit && data_slot && buf_valid) begin
                buf_valid <= 1'b0;
            end else if (load) begin
                buf_valid <= 1'b1;
                buf_bit   <= data_bit;
                fetched   <= fetched + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_gmsk_burst_sequencer.sv
// Scoreboard bench for gmsk_burst_sequencer: the stimulus pushes the expected symbol for every
// strobe it issues, and a monitor pops and compares on each emitting strobe.
module tb_gmsk_burst_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [25:0] train_seq = '0;
    logic [1:0]  steal_flags = '0;
    logic        data_bit = 1'b0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        symbol_strobe = 1'b0;
    logic        current_symbol;
    logic        tx_enable;
    logic        busy;
    logic        burst_done;
    logic        underrun;

    gmsk_burst_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .train_seq     (train_seq),
        .steal_flags   (steal_flags),
        .data_bit      (data_bit),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .symbol_strobe (symbol_strobe),
        .current_symbol(current_symbol),
        .tx_enable     (tx_enable),
        .busy          (busy),
        .burst_done    (burst_done),
        .underrun      (underrun)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic sym;
        logic done;
        logic is_data;
        logic urun;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   failures = 0;

    // Burst context used by the expected-value model and the payload source.
    logic [25:0] cur_train = '0;
    logic [1:0]  cur_steal = '0;
    logic        data_val = 1'b0;
    int          data_mode = 0;  // 0: always valid, 1: valid from strobe 10, 2: sparse early
    int          strobes_issued = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Hand-derived burst layout: head 0-2, data 3-59, steal 60, train 61-86,
    // steal 87, data 88-144, tail 145-147, guard 148-155.
    function automatic exp_t exp_at(input int p);
        exp_t e;
        e = '0;
        if (p <= 2 || (p >= 145 && p <= 147)) begin
            e.sym = 1'b0;
        end else if (p <= 59 || (p >= 88 && p <= 144)) begin
            e.is_data = 1'b1;
            e.sym     = (data_mode == 1 && p <= 9) ? 1'b0 : data_val;
        end else if (p == 60) begin
            e.sym = cur_steal[1];
        end else if (p == 87) begin
            e.sym = cur_steal[0];
        end else if (p <= 86) begin
            e.sym = cur_train[86-p];
        end else begin
            e.sym = 1'b1;
        end
        e.done = (p == 155);
        e.urun = (data_mode == 1) && (p >= 3);
        return e;
    endfunction

    // Payload source, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            data_bit = data_val;
            case (data_mode)
                1:       data_valid = (strobes_issued >= 10);
                2:       data_valid = (strobes_issued >= 3) || (strobes_issued % 2 == 0);
                default: data_valid = 1'b1;
            endcase
        end
    end

    // Monitor: compares on every strobe seen while busy, with its own buffer-occupancy model.
    exp_t pending;
    bit   pending_v = 1'b0;
    bit   model_full = 1'b0;
    int   hs_count = 0;
    int   ready_viol = 0;
    exp_t mon_e;
    bit   mon_hs;
    bit   mon_consume;

    always @(negedge clock) begin
        if (pending_v) begin
            check("symbol", {31'd0, current_symbol}, {31'd0, pending.sym});
            check("underrun", {31'd0, underrun}, {31'd0, pending.urun});
            pending_v = 1'b0;
        end
        mon_hs      = data_valid && data_ready;
        mon_consume = 1'b0;
        if (data_ready && model_full) ready_viol++;
        if (reset && symbol_strobe && busy) begin
            if (sb.size() == 0) begin
                check("unexpected_emission", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("burst_done", {31'd0, burst_done}, {31'd0, mon_e.done});
                pending     = mon_e;
                pending_v   = 1'b1;
                mon_consume = mon_e.is_data;
            end
        end
        if (!reset || (start && !busy)) begin
            model_full = 1'b0;
            hs_count   = 0;
        end else begin
            if (mon_hs) hs_count++;
            if (mon_consume) model_full = mon_hs;
            else if (mon_hs) model_full = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_strobe(input bit push, input int p);
        if (push) sb.push_back(exp_at(p));
        symbol_strobe = 1'b1;
        tick();
        symbol_strobe = 1'b0;
        strobes_issued++;
    endtask

    task automatic start_burst(input logic [25:0] train, input logic [1:0] steal,
                               input logic dval, input int mode);
        cur_train      = train;
        cur_steal      = steal;
        data_val       = dval;
        data_mode      = mode;
        strobes_issued = 0;
        train_seq      = train;
        steal_flags    = steal;
        start          = 1'b1;
        tick();
        start       = 1'b0;
        train_seq   = ~train;
        steal_flags = ~steal;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("tx_enable_after_start", {31'd0, tx_enable}, 32'd1);
        check("underrun_cleared", {31'd0, underrun}, 32'd0);
    endtask

    // Runs strobes every 3 clocks; returns in the cycle right after the last emission.
    task automatic run_burst(input int mid_start_at, input int reset_at);
        int last;
        last = 155;
        for (int p = 0; p < 156; p++) begin
            if (p == mid_start_at) begin
                start     = 1'b1;
                train_seq = 26'h2AAAAAA;
            end
            do_strobe(1'b1, p);
            start = 1'b0;
            if (p == reset_at) begin
                last = p;
                break;
            end
            if (p < 155) begin
                tick();
                tick();
            end
        end
        if (last == 155) begin
            check("tx_enable_after_done", {31'd0, tx_enable}, 32'd0);
            check("busy_after_done", {31'd0, busy}, 32'd0);
            check("symbol_holds_guard", {31'd0, current_symbol}, 32'd1);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_current_symbol"}, {31'd0, current_symbol}, 32'd0);
        check({tag, "_tx_enable"}, {31'd0, tx_enable}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_burst_done"}, {31'd0, burst_done}, 32'd0);
        check({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
        check({tag, "_data_ready"}, {31'd0, data_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b1;
        tick();

        // Nominal burst
        start_burst(26'h0970897, 2'b00, 1'b1, 0);
        run_burst(-1, -1);
        check("t1_handshakes", hs_count, 32'd114);
        check("t1_ready_when_full", ready_viol, 32'd0);
        check("t1_underrun", {31'd0, underrun}, 32'd0);
        repeat (4) tick();

        // Stealing flags with all-zero payload
        start_burst(26'h0970897, 2'b10, 1'b0, 0);
        run_burst(-1, -1);
        check("t2_handshakes", hs_count, 32'd114);
        repeat (4) tick();

        // Underrun: payload withheld until the tenth strobe
        start_burst(26'h3F0F0F1, 2'b01, 1'b1, 1);
        run_burst(-1, -1);
        check("t3_underrun_sticky", {31'd0, underrun}, 32'd1);
        repeat (4) tick();

        // Ignored mid-burst start, then back-to-back start one cycle after burst_done
        start_burst(26'h1234567, 2'b11, 1'b1, 0);
        run_burst(40, -1);
        start_burst(26'h0C3A5F1, 2'b10, 1'b1, 0);

        // Reset in the middle of TRAIN
        run_burst(-1, 70);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_reset_values("midreset");
        for (int i = 0; i < 3; i++) begin
            do_strobe(1'b0, 0);
            tick();
        end
        check("idle_strobe_symbol", {31'd0, current_symbol}, 32'd0);
        check("idle_strobe_busy", {31'd0, busy}, 32'd0);

        // Restart after reset with sparse early payload
        start_burst(26'h1555555, 2'b01, 1'b1, 2);
        run_burst(-1, -1);
        check("t6_handshakes", hs_count, 32'd114);
        check("t6_ready_when_full", ready_viol, 32'd0);
        check("t6_underrun", {31'd0, underrun}, 32'd0);

        repeat (4) tick();
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
